// File: rtl/grant_tenure_ctrl.sv
// grant_tenure_ctrl: turns one-hot arbiter grants into bounded resource
// tenures with a cooldown gap, one pending slot and sticky error flags.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   grant_i      one-hot grant (bit3=user1 .. bit0=user4)
//   release_i    owner ends its tenure early (BUSY only)
//   owner_o      one-hot owner while BUSY, else 0
//   owner_idx_o  encoded owner (0=user1 .. 3=user4), else 0
//   busy_o       high in BUSY
//   pend_o       pending slot holds a grant
//   ovf_o        sticky: a grant event was dropped
//   err_o        sticky: a non-one-hot grant was seen
//   stats_o      per-user tenure-start counters, only present when
//                GRANT_TENURE_STATS_EN is defined
module grant_tenure_ctrl #(
    parameter int TENURE = 16,
    parameter int GAP    = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       grant_i,
    input  logic             release_i,
    output logic [3:0]       owner_o,
    output logic [1:0]       owner_idx_o,
    output logic             busy_o,
    output logic             pend_o,
    output logic             ovf_o,
    output logic             err_o
`ifdef GRANT_TENURE_STATS_EN
    ,
    output logic [4*CNT_W-1:0] stats_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        COOL
    } state_t;

    localparam logic [CNT_W-1:0] T_LOAD = CNT_W'(TENURE - 1);
    localparam logic [CNT_W-1:0] G_LOAD = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] tcnt_q, tcnt_n;
    logic [CNT_W-1:0] gcnt_q, gcnt_n;
    logic [3:0]       own_q, own_n;
    logic [3:0]       pown_q, pown_n;
    logic             pend_q, pend_n;
    logic             ovf_q, ovf_n;
    logic             err_q, err_n;
    logic [3:0]       grant_q;

    logic             changed;
    logic             multi;
    logic             ev;
    logic             bad;
    logic             start;
    logic [3:0]       start_own;
    logic             consume;

    // multi: two or more bits set
    assign changed = (grant_i != grant_q);
    assign multi   = ((grant_i & (grant_i - 4'd1)) != 4'd0);
    assign ev      = changed && (grant_i != 4'd0) && !multi;
    assign bad     = changed && multi;

    always_comb begin
        state_n   = state_q;
        tcnt_n    = tcnt_q;
        gcnt_n    = gcnt_q;
        own_n     = own_q;
        pown_n    = pown_q;
        pend_n    = pend_q;
        ovf_n     = ovf_q;
        err_n     = err_q | bad;
        start     = 1'b0;
        start_own = 4'd0;
        consume   = 1'b0;

        case (state_q)
            IDLE: begin
                // a slot left full on the way into IDLE is served first
                if (pend_q) begin
                    start     = 1'b1;
                    start_own = pown_q;
                    consume   = 1'b1;
                end else if (ev) begin
                    start     = 1'b1;
                    start_own = grant_i;
                end
            end
            BUSY: begin
                if (tcnt_q == '0 || release_i) begin
                    if (GAP > 0) begin
                        state_n = COOL;
                        gcnt_n  = G_LOAD;
                    end else if (pend_q) begin
                        start     = 1'b1;
                        start_own = pown_q;
                        consume   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                    own_n = 4'd0;
                end else begin
                    tcnt_n = tcnt_q - 1'b1;
                end
            end
            COOL: begin
                if (gcnt_q == '0) begin
                    if (pend_q) begin
                        start     = 1'b1;
                        start_own = pown_q;
                        consume   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gcnt_n = gcnt_q - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n = BUSY;
            tcnt_n  = T_LOAD;
            own_n   = start_own;
        end

        if (consume) begin
            pend_n = 1'b0;
        end

        // events not starting a tenure go to the slot
        if (ev && (state_q != IDLE || pend_q)) begin
            if (!pend_q || consume) begin
                pend_n = 1'b1;
                pown_n = grant_i;
            end else begin
                ovf_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            own_q   <= 4'd0;
            pown_q  <= 4'd0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            grant_q <= 4'd0;
        end else begin
            state_q <= state_n;
            tcnt_q  <= tcnt_n;
            gcnt_q  <= gcnt_n;
            own_q   <= own_n;
            pown_q  <= pown_n;
            pend_q  <= pend_n;
            ovf_q   <= ovf_n;
            err_q   <= err_n;
            grant_q <= grant_i;
        end
    end

    assign busy_o  = (state_q == BUSY);
    assign owner_o = busy_o ? own_q : 4'd0;
    assign pend_o  = pend_q;
    assign ovf_o   = ovf_q;
    assign err_o   = err_q;

    always_comb begin
        owner_idx_o = 2'd0;
        unique case (1'b1)
            owner_o[3]: owner_idx_o = 2'd0;
            owner_o[2]: owner_idx_o = 2'd1;
            owner_o[1]: owner_idx_o = 2'd2;
            owner_o[0]: owner_idx_o = 2'd3;
            default:    owner_idx_o = 2'd0;
        endcase
    end

`ifdef GRANT_TENURE_STATS_EN
    logic [4*CNT_W-1:0] stats_q;

    // field b counts tenures for owner bit b; saturates at all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            stats_q <= '0;
        end else if (start) begin
            for (int b = 0; b < 4; b++) begin
                if (start_own[b] &&
                    stats_q[CNT_W*b +: CNT_W] != '1) begin
                    stats_q[CNT_W*b +: CNT_W] <=
                        stats_q[CNT_W*b +: CNT_W] + 1'b1;
                end
            end
        end
    end

    assign stats_o = stats_q;
`else
    // statistics counters not built
`endif

endmodule
